// File: rtl/fsm_out_pkt_pkg.sv
// rtl/fsm_out_pkt_pkg.sv - shared state encoding and helpers for the packet output port FSM
package fsm_out_pkt_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LEN   = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_FLUSH = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    LEN   = ST_LEN,
    DATA  = ST_DATA,
    FLUSH = ST_FLUSH
  } state_t;

  // Saturating increment for counters up to 32 bits wide.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned width);
    logic [31:0] max_val;
    max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (val >= max_val) ? val : val + 32'd1;
  endfunction

endpackage

// File: rtl/out_watchdog.sv
// rtl/out_watchdog.sv - consumer-stall counter that flags the TIMEOUT-th consecutive stalled cycle
module out_watchdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic kick,
  input  logic stall,
  output logic expired
);

  localparam int WD_WIDTH = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  generate
    if (TIMEOUT == 0) begin : g_off
      assign expired = 1'b0;
    end else begin : g_on
      localparam logic [WD_WIDTH-1:0] LIMIT = WD_WIDTH'(TIMEOUT - 1);
      logic [WD_WIDTH-1:0] wd_cnt;

      always_ff @(posedge clk) begin
        if (rst || kick) begin
          wd_cnt <= '0;
        end else if (stall) begin
          wd_cnt <= wd_cnt + WD_WIDTH'(1);
        end
      end

      // Fires combinationally on the stall that would take the count to TIMEOUT.
      assign expired = stall && (wd_cnt == LIMIT);
    end
  endgenerate

endmodule

// File: rtl/fsm_out_pkt.sv
// rtl/fsm_out_pkt.sv - packet-aware switch output port: filter, forward, stall watchdog, statistics
module fsm_out_pkt
  import fsm_out_pkt_pkg::*;
#(
  parameter int W_WIDTH   = 8,
  parameter int TIMEOUT   = 16,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sw_en,
  input  logic [W_WIDTH-1:0]   port_addr,
  input  logic [W_WIDTH-1:0]   fifo_data,
  input  logic                 fifo_empty,
  output logic                 rd_en,
  input  logic                 port_rd,
  output logic                 port_valid,
  output logic [W_WIDTH-1:0]   port_out,
  output logic                 busy,
  output logic                 pkt_drop,
  output logic [CNT_WIDTH-1:0] fwd_cnt,
  output logic [CNT_WIDTH-1:0] drop_cnt
);

  state_t             state;
  logic [W_WIDTH-1:0] cnt;
  logic               drop_flag;
  logic               xfer;
  logic               stall;
  logic               kick;
  logic               expired;

  always_comb begin
    rd_en      = 1'b0;
    port_valid = 1'b0;
    if (!rst) begin
      case (state)
        IDLE:  rd_en = sw_en && !fifo_empty;
        LEN:   rd_en = !fifo_empty;
        DATA: begin
          port_valid = !fifo_empty;
          rd_en      = !fifo_empty && port_rd;
        end
        FLUSH: rd_en = !fifo_empty;
        default: ;
      endcase
    end
  end

  assign port_out = port_valid ? fifo_data : '0;
  assign busy     = !rst && (state != IDLE);
  assign xfer     = (state == DATA) && rd_en;
  assign stall    = port_valid && !port_rd;
  assign kick     = (state != DATA) || xfer;

  out_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .kick    (kick),
    .stall   (stall),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      drop_flag <= 1'b0;
      pkt_drop  <= 1'b0;
      fwd_cnt   <= '0;
      drop_cnt  <= '0;
    end else begin
      pkt_drop <= 1'b0;
      case (state)
        IDLE: begin
          if (rd_en) begin
            drop_flag <= (fifo_data != port_addr);
            state     <= LEN;
          end
        end
        LEN: begin
          if (rd_en) begin
            cnt <= fifo_data;
            if (fifo_data == '0) begin
              state <= IDLE;
              if (drop_flag) begin
                pkt_drop <= 1'b1;
                drop_cnt <= CNT_WIDTH'(sat_inc(32'(drop_cnt), CNT_WIDTH));
              end else begin
                fwd_cnt <= CNT_WIDTH'(sat_inc(32'(fwd_cnt), CNT_WIDTH));
              end
            end else begin
              state <= drop_flag ? FLUSH : DATA;
            end
          end
        end
        DATA: begin
          if (xfer) begin
            cnt <= cnt - W_WIDTH'(1);
            if (cnt == W_WIDTH'(1)) begin
              state   <= IDLE;
              fwd_cnt <= CNT_WIDTH'(sat_inc(32'(fwd_cnt), CNT_WIDTH));
            end
          end else if (expired) begin
            // cnt still includes the un-popped head word, so FLUSH drains exactly the rest.
            state <= FLUSH;
          end
        end
        FLUSH: begin
          if (rd_en) begin
            cnt <= cnt - W_WIDTH'(1);
            if (cnt == W_WIDTH'(1)) begin
              state    <= IDLE;
              pkt_drop <= 1'b1;
              drop_cnt <= CNT_WIDTH'(sat_inc(32'(drop_cnt), CNT_WIDTH));
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fsm_out_pkt.sv
// tb/tb_fsm_out_pkt.sv - scoreboard bench for fsm_out_pkt with directed packet vectors
module tb_fsm_out_pkt;

  logic        clk = 1'b0;
  logic        rst;
  logic        sw_en;
  logic [7:0]  port_addr;
  logic [7:0]  fifo_data;
  logic        fifo_empty;
  logic        rd_en;
  logic        port_rd;
  logic        port_valid;
  logic [7:0]  port_out;
  logic        busy;
  logic        pkt_drop;
  logic [15:0] fwd_cnt;
  logic [15:0] drop_cnt;

  always #5 clk = ~clk;

  fsm_out_pkt #(.W_WIDTH(8), .TIMEOUT(4), .CNT_WIDTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .sw_en      (sw_en),
    .port_addr  (port_addr),
    .fifo_data  (fifo_data),
    .fifo_empty (fifo_empty),
    .rd_en      (rd_en),
    .port_rd    (port_rd),
    .port_valid (port_valid),
    .port_out   (port_out),
    .busy       (busy),
    .pkt_drop   (pkt_drop),
    .fwd_cnt    (fwd_cnt),
    .drop_cnt   (drop_cnt)
  );

  logic [7:0] fq[$];
  logic [7:0] exp_q[$];
  logic [7:0] pk[$];
  int n_cmp = 0;
  int n_bad = 0;
  int pops, drops, stalls, valids, cyc, first_pop, last_pop;
  logic pop_pend;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic refresh();
    fifo_empty = (fq.size() == 0);
    fifo_data  = fifo_empty ? 8'h00 : fq[0];
  endtask

  // Pops the bench FIFO just after each edge where the DUT asserted rd_en.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (pop_pend && fq.size() > 0) void'(fq.pop_front());
      refresh();
      #1;
    end
  endtask

  task automatic load(input logic [7:0] w[$], input int exp_from);
    foreach (w[i]) begin
      fq.push_back(w[i]);
      if (i >= exp_from) exp_q.push_back(w[i]);
    end
    refresh();
  endtask

  task automatic clear_stats();
    pops = 0; drops = 0; stalls = 0; valids = 0; first_pop = -1; last_pop = 0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k = 0;
    while ((busy || fq.size() != 0) && k < budget) begin
      step(1);
      k++;
    end
    check({name, "_done"}, {31'd0, (busy || fq.size() != 0)}, 32'd0);
    step(2);
  endtask

  task automatic monitor_loop();
    logic [7:0] e;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        check("rst_rd_en", {31'd0, rd_en}, 32'd0);
        check("rst_port_valid", {31'd0, port_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
      end else begin
        if (rd_en) begin
          pops++;
          if (first_pop < 0) first_pop = cyc;
          last_pop = cyc;
        end
        if (pkt_drop) drops++;
        if (port_valid) valids++;
        if (port_valid && !port_rd) stalls++;
        if (port_valid && port_rd) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sb_unexpected: got %0h expected no word", port_out);
          end else begin
            e = exp_q.pop_front();
            check("sb_word", {24'd0, port_out}, {24'd0, e});
          end
        end
      end
      if (!port_valid) check("port_out_zero", {24'd0, port_out}, 32'd0);
      pop_pend = rd_en;
    end
  endtask

  initial begin
    rst = 1'b1; sw_en = 1'b0; port_rd = 1'b0; port_addr = 8'h03;
    pop_pend = 1'b0; cyc = 0;
    clear_stats();
    refresh();
    fork
      monitor_loop();
    join_none
    step(3);
    check("reset_fwd_cnt", {16'd0, fwd_cnt}, 32'd0);
    check("reset_drop_cnt", {16'd0, drop_cnt}, 32'd0);
    check("reset_pkt_drop", {31'd0, pkt_drop}, 32'd0);
    rst = 1'b0;
    step(1);
    check("reset_busy", {31'd0, busy}, 32'd0);

    // matching packet, consumer always ready
    clear_stats(); sw_en = 1'b1; port_rd = 1'b1;
    pk = '{8'h03, 8'h02, 8'hA1, 8'hA2}; load(pk, 2);
    wait_idle("t1", 40);
    check("t1_pops", pops, 4);
    check("t1_consecutive", last_pop - first_pop, 3);
    check("t1_fwd_cnt", {16'd0, fwd_cnt}, 1);
    check("t1_drops", drops, 0);

    // address mismatch: whole packet flushed
    clear_stats();
    pk = '{8'h05, 8'h03, 8'h11, 8'h22, 8'h33}; load(pk, 5);
    wait_idle("t2", 40);
    check("t2_pops", pops, 5);
    check("t2_valids", valids, 0);
    check("t2_drops", drops, 1);
    check("t2_drop_cnt", {16'd0, drop_cnt}, 1);
    check("t2_fwd_cnt", {16'd0, fwd_cnt}, 1);

    // consumer stalls until the watchdog fires
    clear_stats(); port_rd = 1'b0;
    pk = '{8'h03, 8'h03, 8'hB1, 8'hB2, 8'hB3}; load(pk, 5);
    wait_idle("t3", 60);
    check("t3_stalls", stalls, 4);
    check("t3_valids", valids, 4);
    check("t3_pops", pops, 5);
    check("t3_drops", drops, 1);
    check("t3_drop_cnt", {16'd0, drop_cnt}, 2);
    clear_stats(); port_rd = 1'b1;
    pk = '{8'h03, 8'h01, 8'hE1}; load(pk, 2);
    wait_idle("t3b", 40);
    check("t3b_fwd_cnt", {16'd0, fwd_cnt}, 2);
    check("t3b_pops", pops, 3);
    check("t3b_drops", drops, 0);

    // three stalls, one short of the limit, then resume
    clear_stats(); port_rd = 1'b0;
    pk = '{8'h03, 8'h02, 8'hF1, 8'hF2}; load(pk, 2);
    step(5);
    port_rd = 1'b1;
    wait_idle("t4", 40);
    check("t4_stalls", stalls, 3);
    check("t4_drops", drops, 0);
    check("t4_fwd_cnt", {16'd0, fwd_cnt}, 3);

    // empty FIFO mid-payload holds the watchdog
    clear_stats(); port_rd = 1'b1;
    pk = '{8'h03, 8'h03, 8'hC1}; load(pk, 2);
    step(12);
    check("t4b_waiting_busy", {31'd0, busy}, 1);
    check("t4b_no_stall_yet", stalls, 0);
    port_rd = 1'b0;
    pk = '{8'hC2, 8'hC3}; load(pk, 0);
    step(3);
    port_rd = 1'b1;
    wait_idle("t4b", 40);
    check("t4b_stalls", stalls, 3);
    check("t4b_drops", drops, 0);
    check("t4b_fwd_cnt", {16'd0, fwd_cnt}, 4);
    check("t4b_pops", pops, 5);

    // sw_en dropped mid-packet does not abort it
    clear_stats();
    pk = '{8'h03, 8'h03, 8'hD7, 8'hD8, 8'hD9}; load(pk, 2);
    step(3);
    sw_en = 1'b0;
    wait_idle("t5", 40);
    check("t5_fwd_cnt", {16'd0, fwd_cnt}, 5);
    clear_stats();
    pk = '{8'h03, 8'h01, 8'h4C}; load(pk, 2);
    step(5);
    check("t5_idle_wait_busy", {31'd0, busy}, 0);
    check("t5_idle_wait_pops", pops, 0);
    check("t5_idle_wait_fifo", fq.size(), 3);
    sw_en = 1'b1;
    wait_idle("t5b", 40);
    check("t5b_fwd_cnt", {16'd0, fwd_cnt}, 6);
    check("t5b_pops", pops, 3);

    // zero-length packets, matching and mismatching
    clear_stats();
    pk = '{8'h03, 8'h00}; load(pk, 2);
    wait_idle("t5c", 40);
    check("t5c_pops", pops, 2);
    check("t5c_valids", valids, 0);
    check("t5c_fwd_cnt", {16'd0, fwd_cnt}, 7);
    check("t5c_drops", drops, 0);
    clear_stats();
    pk = '{8'h05, 8'h00}; load(pk, 2);
    wait_idle("t5d", 40);
    check("t5d_drops", drops, 1);
    check("t5d_drop_cnt", {16'd0, drop_cnt}, 3);
    check("t5d_fwd_cnt", {16'd0, fwd_cnt}, 7);

    // back-to-back packets with no dead cycle
    clear_stats();
    pk = '{8'h03, 8'h01, 8'h61, 8'h03, 8'h01, 8'h62}; load(pk, 6);
    exp_q.push_back(8'h61); exp_q.push_back(8'h62);
    wait_idle("t5e", 40);
    check("t5e_pops", pops, 6);
    check("t5e_consecutive", last_pop - first_pop, 5);
    check("t5e_fwd_cnt", {16'd0, fwd_cnt}, 9);

    // reset in DATA with cnt=5
    check("t6_pre_fwd_cnt", {16'd0, fwd_cnt}, 9);
    check("t6_pre_drop_cnt", {16'd0, drop_cnt}, 3);
    clear_stats(); port_rd = 1'b0;
    pk = '{8'h03, 8'h05, 8'h71, 8'h72, 8'h73, 8'h74, 8'h75}; load(pk, 7);
    step(2);
    check("t6_in_data_busy", {31'd0, busy}, 1);
    rst = 1'b1;
    step(1);
    check("t6_rst_fwd_cnt", {16'd0, fwd_cnt}, 0);
    check("t6_rst_drop_cnt", {16'd0, drop_cnt}, 0);
    check("t6_rst_pkt_drop", {31'd0, pkt_drop}, 0);
    sw_en = 1'b0;
    fq.delete();
    refresh();
    rst = 1'b0;
    step(1);
    check("t6_busy", {31'd0, busy}, 0);
    step(3);
    check("t6_drops", drops, 0);
    check("t6_pops", pops, 2);
    check("sb_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fsm_out_pkt.md
Name: fsm_out_pkt

Overview:
- Packet-aware successor to the switch output-port FSM.
- Pops framed packets from its output FIFO: header word is the destination address, then a length word, then payload words.
- Forwards the payload to the port consumer under a valid/read handshake.
- Adds address filtering, a consumer-stall watchdog that drops the rest of a packet, and drop/forward statistics.
- Sits between one switch output FIFO (show-ahead) and one output port.

Parameters:
- W_WIDTH, 8, width of address, length, data and port words.
- TIMEOUT, 16, consumer-stall cycles before the packet is dropped; 0 disables the watchdog.
- CNT_WIDTH, 16, width of the forwarded and dropped packet counters (saturating).

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- sw_en  in  1  switch enable; gates only the start of a new packet.
- port_addr  in  W_WIDTH  this port's address; compared with the header word.
- fifo_data  in  W_WIDTH  FIFO head word; valid whenever fifo_empty=0 (show-ahead).
- fifo_empty  in  1  FIFO empty flag.
- rd_en  out  1  pop strobe; the word on fifo_data is consumed in the cycle rd_en=1.
- port_rd  in  1  consumer accepts port_out in this cycle.
- port_valid  out  1  port_out holds a payload word.
- port_out  out  W_WIDTH  payload word; equals fifo_data when port_valid=1, otherwise 0.
- busy  out  1  state is not IDLE.
- pkt_drop  out  1  one-cycle registered pulse when a packet is dropped.
- fwd_cnt  out  CNT_WIDTH  packets fully forwarded.
- drop_cnt  out  CNT_WIDTH  packets dropped (address mismatch or timeout).

Behaviour:
- Reset, while rst=1: state=IDLE, length counter=0, watchdog=0, drop flag=0, fwd_cnt=0, drop_cnt=0, pkt_drop=0.
- During reset, combinational outputs are rd_en=0, port_valid=0, port_out=0, busy=0.
- Reset mid-packet abandons the packet with no pkt_drop. Any remaining FIFO words are then parsed as a new header.
- IDLE:
  - If sw_en=1 and fifo_empty=0: rd_en=1 (pop header), drop flag <= (fifo_data != port_addr), go to LEN.
  - Otherwise stay in IDLE.
  - sw_en=0 never aborts a packet already in progress.
- LEN:
  - If fifo_empty=0: rd_en=1 and cnt <= fifo_data.
  - If fifo_data=0 (empty packet): go to IDLE; if drop flag=1, pkt_drop pulses next cycle and drop_cnt increments; otherwise fwd_cnt increments.
  - If fifo_data!=0: go to FLUSH when drop flag=1, otherwise DATA.
- DATA:
  - port_valid = !fifo_empty; rd_en = port_valid & port_rd.
  - Each transfer: cnt <= cnt-1 and watchdog <= 0.
  - Transfer with cnt=1: go to IDLE and increment fwd_cnt.
  - Watchdog increments only while port_valid=1 & port_rd=0. An empty FIFO holds the watchdog.
  - When the watchdog reaches TIMEOUT-1 and the consumer stalls again (i.e. the TIMEOUT-th consecutive stalled valid cycle): go to FLUSH with cnt unchanged. The word on fifo_data in that cycle is not popped.
- FLUSH:
  - rd_en = !fifo_empty; port_valid=0; cnt decrements on each pop.
  - Pop with cnt=1: go to IDLE, pkt_drop pulses the next cycle, drop_cnt increments.
- Back-to-back packets: a header can be popped in the cycle after the last payload pop. There is no dead cycle beyond the return to IDLE.
- Counters saturate at all-ones.
- Length is an unsigned W_WIDTH value, so the maximum payload is 2^W_WIDTH-1 words.
- Watchdog width is clog2(TIMEOUT+1).

Decomposition:
- Package fsm_out_pkt_pkg holds:
  - state enum {IDLE, LEN, DATA, FLUSH};
  - a saturating-increment function.
- Sub-module out_watchdog (params TIMEOUT; ports clk, rst, kick, stall, expired) holds the stall counter and timeout compare. TIMEOUT=0 ties expired to 0.

Test Plan:
- Match, no stall: port_addr=8'h03; FIFO {03,02,A1,A2}; sw_en=1, port_rd=1 -> rd_en on 4 consecutive cycles; port_out A1 then A2 with port_valid; fwd_cnt=1; pkt_drop=0.
- Address mismatch: port_addr=8'h03; FIFO {05,03,11,22,33} -> port_valid never 1; 5 pops; pkt_drop pulses once; drop_cnt=1.
- Timeout: TIMEOUT=4; packet {03,03,B1,B2,B3}; port_rd=0 -> port_valid high for 4 cycles; B1 then flushed along with B2 and B3; pkt_drop=1; drop_cnt=1; next packet forwarded normally.
- Stall below the limit, consumer then resumes: port_rd=0 for 3 cycles (TIMEOUT=4), then 1 -> packet completes; fwd_cnt=1; no drop. Also check that an empty FIFO mid-payload for 10 cycles does not time out.
- sw_en=0 mid-packet and length 0: deassert sw_en during DATA -> packet finishes and IDLE waits. Packet {03,00} -> header and length popped, fwd_cnt increments, no payload.
- rst=1 in DATA with cnt=5 -> next cycle state IDLE, counters 0, rd_en=0 during reset, no pkt_drop.
